// File: rtl/dmaster_st_channel_arbiter.sv
// Packet-aware round-robin arbiter: grants one Avalon-ST source for a whole packet,
// tags each beat with its source index and drives a registered, backpressured output.
module dmaster_st_channel_arbiter #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CH_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_startofpacket,
   input  logic [NUM_CH-1:0]        in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_startofpacket,
   output logic                     out_endofpacket,
   output logic [CH_W-1:0]          out_channel,
   output logic                     grant_busy
);

   localparam int unsigned GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t          state;
   logic [GW-1:0]   grant;
   logic [GW-1:0]   ptr;
   logic [GW-1:0]   pick;
   logic [GW-1:0]   grant_next;
   logic            slot_open;
   logic            accept;
   logic [DATA_W-1:0] beat_data;
   logic            beat_sop;
   logic            beat_eop;

   // The output slot is free when empty or draining this cycle; never depends on in_valid.
   assign slot_open = ~out_valid | out_ready;

   always_comb begin
      in_ready = '0;
      if (state == LOCKED) in_ready[grant] = slot_open;
   end

   always_comb begin
      beat_data = in_data[32'(grant) * DATA_W +: DATA_W];
      beat_sop  = in_startofpacket[grant];
      beat_eop  = in_endofpacket[grant];
      accept    = (state == LOCKED) & in_valid[grant] & slot_open;
   end

   // Scan downward from the farthest candidate so the nearest request at or after ptr wins.
   always_comb begin
      int unsigned   idx;
      logic [GW-1:0] cand;
      idx  = 0;
      cand = '0;
      pick = ptr;
      for (int unsigned i = NUM_CH; i > 0; i--) begin
         idx = 32'(ptr) + i - 1;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         cand = GW'(idx);
         if (in_valid[cand]) pick = cand;
      end
   end

   always_comb begin
      if (32'(grant) == NUM_CH - 1) grant_next = '0;
      else                          grant_next = grant + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         grant             <= '0;
         ptr               <= '0;
         grant_busy        <= 1'b0;
         out_valid         <= 1'b0;
         out_data          <= '0;
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         out_channel       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|in_valid) begin
                  grant      <= pick;
                  state      <= LOCKED;
                  grant_busy <= 1'b1;
               end
            end
            LOCKED: begin
               if (accept && beat_eop) begin
                  state      <= IDLE;
                  ptr        <= grant_next;
                  grant_busy <= 1'b0;
               end
            end
         endcase

         if (accept) begin
            out_valid         <= 1'b1;
            out_data          <= beat_data;
            out_startofpacket <= beat_sop;
            out_endofpacket   <= beat_eop;
            out_channel       <= CH_W'(grant);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmaster_st_channel_arbiter.sv
// Directed bench for dmaster_st_channel_arbiter: per-cycle comparison against a
// packet-level arbitration model plus hand-computed expectations per scenario.
module tb_dmaster_st_channel_arbiter;

   localparam int NUM_CH = 4;
   localparam int DATA_W = 8;
   localparam int CH_W   = 8;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b1;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH-1:0]        in_startofpacket;
   logic [NUM_CH-1:0]        in_endofpacket;
   logic                     out_ready;
   logic                     out_valid;
   logic [DATA_W-1:0]        out_data;
   logic                     out_startofpacket;
   logic                     out_endofpacket;
   logic [CH_W-1:0]          out_channel;
   logic                     grant_busy;

   always #5 clk = ~clk;

   dmaster_st_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .in_startofpacket  (in_startofpacket),
      .in_endofpacket    (in_endofpacket),
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_startofpacket),
      .out_endofpacket   (out_endofpacket),
      .out_channel       (out_channel),
      .grant_busy        (grant_busy)
   );

   // Per-source beat queues: {sop, eop, data}
   logic [9:0]  mem [NUM_CH][32];
   int unsigned head [NUM_CH];
   int unsigned tail [NUM_CH];
   logic [NUM_CH-1:0] en;
   int flush_req = 0;
   int flush_seen = 0;

   // Source driver: pops beats the DUT accepted, presents the next head beat.
   initial begin
      logic [NUM_CH-1:0] fire;
      for (int i = 0; i < NUM_CH; i++) head[i] = 0;
      in_valid = '0; in_data = '0; in_startofpacket = '0; in_endofpacket = '0;
      forever begin
         @(negedge clk);
         fire = in_valid & in_ready;
         @(posedge clk); #1;
         for (int i = 0; i < NUM_CH; i++) if (fire[i]) head[i]++;
         if (flush_seen != flush_req) begin
            for (int i = 0; i < NUM_CH; i++) head[i] = tail[i];
            flush_seen = flush_req;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (en[i] && head[i] != tail[i]) begin
               in_valid[i]                 = 1'b1;
               in_startofpacket[i]         = mem[i][head[i] % 32][9];
               in_endofpacket[i]           = mem[i][head[i] % 32][8];
               in_data[i*DATA_W +: DATA_W] = mem[i][head[i] % 32][7:0];
            end else begin
               in_valid[i] = 1'b0;
            end
         end
      end
   end

   // Packet-level model: owner = source holding the output (-1 none), rr = next scan start.
   int m_owner = -1;
   int m_rr    = 0;
   int m_ov    = 0;
   int m_data  = 0;
   int m_sop   = 0;
   int m_eop   = 0;
   int m_ch    = 0;

   always @(posedge clk or negedge reset_n) begin
      int own, rr, ov, d, s, e, c;
      if (!reset_n) begin
         m_owner <= -1; m_rr <= 0; m_ov <= 0; m_data <= 0;
         m_sop <= 0; m_eop <= 0; m_ch <= 0;
      end else begin
         own = m_owner; rr = m_rr; ov = m_ov; d = m_data; s = m_sop; e = m_eop; c = m_ch;
         if (own < 0) begin
            for (int k = 0; k < NUM_CH; k++)
               if (own < 0 && in_valid[(rr + k) % NUM_CH]) own = (rr + k) % NUM_CH;
            if (out_ready) ov = 0;
         end else if ((ov == 0 || out_ready) && in_valid[own]) begin
            ov = 1;
            d  = int'(in_data[own*DATA_W +: DATA_W]);
            s  = int'(in_startofpacket[own]);
            e  = int'(in_endofpacket[own]);
            c  = own;
            if (e != 0) begin
               rr  = (own + 1) % NUM_CH;
               own = -1;
            end
         end else if (out_ready) begin
            ov = 0;
         end
         m_owner <= own; m_rr <= rr; m_ov <= ov; m_data <= d;
         m_sop <= s; m_eop <= e; m_ch <= c;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int log_data [64];
   int log_ch   [64];
   int log_sop  [64];
   int log_eop  [64];
   int log_cyc  [64];
   int log_n    = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic compare_loop();
      int exp_rdy;
      forever begin
         @(negedge clk);
         cyc++;
         exp_rdy = (m_owner >= 0 && (m_ov == 0 || out_ready)) ? (1 << m_owner) : 0;
         chk("out_valid", int'(out_valid), m_ov);
         chk("out_data", int'(out_data), m_data);
         chk("out_sop", int'(out_startofpacket), m_sop);
         chk("out_eop", int'(out_endofpacket), m_eop);
         chk("out_channel", int'(out_channel), m_ch);
         chk("grant_busy", int'(grant_busy), (m_owner >= 0) ? 1 : 0);
         chk("in_ready", int'(in_ready), exp_rdy);
         if (out_valid && out_ready && log_n < 64) begin
            log_data[log_n] = int'(out_data);
            log_ch[log_n]   = int'(out_channel);
            log_sop[log_n]  = int'(out_startofpacket);
            log_eop[log_n]  = int'(out_endofpacket);
            log_cyc[log_n]  = cyc;
            log_n++;
         end
      end
   endtask

   task automatic push(input int s, input bit sop, input bit eop, input int d);
      mem[s][tail[s] % 32] = {sop, eop, 8'(d)};
      tail[s]++;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_log(input int n, input string name);
      int k = 0;
      while (log_n < n && k < 300) begin tick(); k++; end
      chk(name, (log_n >= n) ? 1 : 0, 1);
   endtask

   function automatic bit busy_now();
      bit b = out_valid | grant_busy;
      for (int i = 0; i < NUM_CH; i++) if (head[i] != tail[i]) b = 1'b1;
      return b;
   endfunction

   task automatic wait_drain(input string name);
      int k = 0;
      while (busy_now() && k < 300) begin tick(); k++; end
      tick();
      chk(name, busy_now() ? 1 : 0, 0);
   endtask

   initial begin
      int st;
      for (int i = 0; i < NUM_CH; i++) tail[i] = 0;
      en = '1;
      out_ready = 1'b1;
      fork compare_loop(); join_none
      #1 reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // Single source, 3-beat packet on source 2
      st = log_n;
      push(2, 1, 0, 'hA1); push(2, 0, 0, 'hA2); push(2, 0, 1, 'hA3);
      wait_drain("t1_drain");
      chk("t1_count", log_n - st, 3);
      for (int k = 0; k < 3; k++) begin
         chk("t1_data", log_data[st+k], 'hA1 + k);
         chk("t1_ch", log_ch[st+k], 2);
         chk("t1_sop", log_sop[st+k], (k == 0) ? 1 : 0);
         chk("t1_eop", log_eop[st+k], (k == 2) ? 1 : 0);
         if (k > 0) chk("t1_gap", log_cyc[st+k] - log_cyc[st+k-1], 1);
      end
      chk("t1_model_rr", m_rr, 3);

      // Round robin: every source offers two 2-beat packets; scan starts at 3
      st = log_n;
      for (int p = 0; p < 2; p++)
         for (int s = 0; s < NUM_CH; s++)
            for (int b = 0; b < 2; b++) push(s, b == 0, b == 1, s*16 + p*4 + b);
      wait_drain("t2_drain");
      chk("t2_count", log_n - st, 16);
      for (int k = 0; k < 16; k++) begin
         int pk, b, ch;
         pk = k / 2; b = k % 2; ch = (3 + pk) % 4;
         chk("t2_ch", log_ch[st+k], ch);
         chk("t2_data", log_data[st+k], ch*16 + (pk/4)*4 + b);
         chk("t2_sop", log_sop[st+k], (b == 0) ? 1 : 0);
         chk("t2_eop", log_eop[st+k], b);
         if (k > 0) chk("t2_gap", log_cyc[st+k] - log_cyc[st+k-1], (b == 0) ? 2 : 1);
      end

      // Backpressure mid-packet on source 0
      st = log_n;
      push(0, 1, 0, 'hC0); push(0, 0, 0, 'hC1); push(0, 0, 0, 'hC2); push(0, 0, 1, 'hC3);
      wait_log(st + 2, "t3_wait");
      out_ready = 1'b0;
      repeat (5) tick();
      chk("t3_hold_valid", int'(out_valid), 1);
      chk("t3_hold_ready", int'(in_ready), 0);
      out_ready = 1'b1;
      wait_drain("t3_drain");
      chk("t3_count", log_n - st, 4);
      for (int k = 0; k < 4; k++) begin
         chk("t3_data", log_data[st+k], 'hC0 + k);
         chk("t3_ch", log_ch[st+k], 0);
      end
      chk("t3_model_rr", m_rr, 1);

      // Reset during beat 2 of a 4-beat packet on source 1
      st = log_n;
      push(1, 1, 0, 'hD0); push(1, 0, 0, 'hD1); push(1, 0, 0, 'hD2); push(1, 0, 1, 'hD3);
      wait_log(st + 1, "t6_wait");
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sop", int'(out_startofpacket), 0);
      chk("rst_out_eop", int'(out_endofpacket), 0);
      chk("rst_out_channel", int'(out_channel), 0);
      chk("rst_grant_busy", int'(grant_busy), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      flush_req++;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();

      // Single-beat packets from sources 1 and 3 after reset (scan restarts at 0)
      st = log_n;
      push(1, 1, 1, 'h55); push(3, 1, 1, 'h66);
      wait_drain("t4_drain");
      chk("t4_count", log_n - st, 2);
      chk("t4_data0", log_data[st], 'h55);
      chk("t4_ch0", log_ch[st], 1);
      chk("t4_data1", log_data[st+1], 'h66);
      chk("t4_ch1", log_ch[st+1], 3);
      chk("t4_soeop", log_sop[st] & log_eop[st] & log_sop[st+1] & log_eop[st+1], 1);
      chk("t4_gap", log_cyc[st+1] - log_cyc[st], 2);
      chk("t4_model_rr", m_rr, 0);

      // Granted source 0 stalls mid-packet while source 1 waits
      st = log_n;
      push(0, 1, 0, 'hE0); push(0, 0, 0, 'hE1); push(0, 0, 1, 'hE2);
      wait_log(st + 1, "t5_wait");
      en[0] = 1'b0;
      push(1, 1, 1, 'hF0);
      repeat (4) tick();
      chk("t5_busy", int'(grant_busy), 1);
      chk("t5_ready1", int'(in_ready[1]), 0);
      en[0] = 1'b1;
      wait_drain("t5_drain");
      chk("t5_count", log_n - st, 4);
      for (int k = 0; k < 3; k++) begin
         chk("t5_data", log_data[st+k], 'hE0 + k);
         chk("t5_ch", log_ch[st+k], 0);
      end
      chk("t5_data_f", log_data[st+3], 'hF0);
      chk("t5_ch_f", log_ch[st+3], 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmaster_st_channel_arbiter.md
# dmaster_st_channel_arbiter

Packet-aware round-robin arbiter that shares the single Avalon-ST byte-stream path into the debug-master packets-to-bytes channel adapter among up to eight packet sources. It grants the output to one source for a whole packet, from startofpacket through endofpacket. It tags every beat with the source index on `out_channel` and drives a registered output stage with full ready/valid backpressure. It sits between the per-requester packet generators and the channel adapter in the EMIF debug-master path.

## Interface
- `NUM_CH`, 4, number of input sources; legal range 2..8
- `DATA_W`, 8, beat data width
- `CH_W`, 8, output channel width; must satisfy NUM_CH <= 2^CH_W

- `clk`  in  1  single clock; all logic rising-edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  NUM_CH  per-source valid
- `in_ready`  out  NUM_CH  per-source ready
- `in_data`  in  NUM_CH*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- `in_startofpacket`  in  NUM_CH  per-source SOP
- `in_endofpacket`  in  NUM_CH  per-source EOP
- `out_ready`  in  1  downstream ready
- `out_valid`  out  1  registered valid
- `out_data`  out  DATA_W  registered data
- `out_startofpacket`  out  1  registered SOP
- `out_endofpacket`  out  1  registered EOP
- `out_channel`  out  CH_W  registered source index, zero-extended
- `grant_busy`  out  1  high while the FSM is in LOCKED

## Operation
- FSM states: IDLE, LOCKED. Registers: `grant` (index), `ptr` (round-robin start index), output register.
- IDLE: if any in_valid is high, select the first set bit scanning from `ptr` upward, wrapping modulo NUM_CH. Load `grant`, go to LOCKED. No beat is accepted in IDLE.
- LOCKED: `in_ready[grant]` = ~out_valid | out_ready. All other in_ready are 0. A beat is accepted when in_valid[grant] & in_ready[grant].
- Accepted beat loads the output register: data, SOP, EOP, and out_channel = grant.
- Accepted beat with EOP=1: go to IDLE; `ptr` <= (grant+1) mod NUM_CH. A single-beat packet (SOP=EOP=1) follows the same rule.
- The arbiter does not check SOP. Beats pass through as presented. Grant release depends only on the EOP of an accepted beat.
- Non-granted sources are stalled (in_ready=0) for the whole of another source's packet, however long.
- in_valid deasserting mid-packet on the granted source does not release the grant. The FSM stays LOCKED indefinitely.

## Timing
- Reset (asynchronous assert, synchronous-clean release): state=IDLE, grant=0, ptr=0, out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0, grant_busy=0, in_ready=0.
- Reset mid-packet discards the partial packet and any held output beat. After release, arbitration restarts from index 0.
- Arbitration costs one cycle per packet: request seen in IDLE in cycle N, first beat accepted no earlier than cycle N+1.
- Latency from input acceptance to out_valid is 1 cycle.
- Throughput is 1 beat/cycle within a packet while out_ready=1.
- Output register rules:
  - Holds its value and out_valid while out_valid & ~out_ready.
  - Clears out_valid on out_ready when no new beat is accepted the same cycle.
  - Accepts a new beat in the same cycle the current beat drains.
- Simultaneous EOP acceptance and new requests: the new grant is decided in the following IDLE cycle using the updated `ptr`.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid to in_ready.

## Test plan
- Single source: source 2 sends a 3-beat packet 0xA1,0xA2,0xA3, out_ready=1 -> out emits the 3 beats on consecutive cycles. SOP on 0xA1, EOP on 0xA3, out_channel=2 on every beat. ptr ends at 3.
- Round-robin fairness: all 4 sources continuously offer 2-beat packets -> grant order 0,1,2,3,0,… with one idle cycle between packets. No interleaving of beats from different sources inside a packet.
- Backpressure: out_ready held 0 for 5 cycles mid-packet -> out_valid and out_data stable throughout, in_ready[grant]=0, no beat lost or duplicated. Resume at full rate when out_ready returns to 1.
- Single-beat packets: sources 1 and 3 each send SOP=EOP=1 beats 0x55 and 0x66 simultaneously from ptr=0 -> 0x55 with channel 1 first, then 0x66 with channel 3. Each beat is preceded by one arbitration cycle.
- Source gap: granted source 0 drops in_valid for 4 cycles mid-packet while source 1 requests -> grant stays on 0, in_ready[1]=0, source 1 is granted only after source 0's EOP is accepted.
- Reset mid-packet: assert reset_n=0 during beat 2 of 4 -> all outputs go to 0 immediately. After release, the next grant goes to the lowest requesting index starting from 0.
